// File: rtl/lzss_packer.sv
// LZSS codeword bit packer: 9/11-bit codewords into MSB-first 32-bit words.
// Define LZSS_PACK_STAT_EN to enable the literal/match statistics counters.
module lzss_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] codeword,
    input  logic        cw_valid,
    output logic        cw_ready,
    input  logic        finish,
    output logic [31:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic        done,
    output logic [19:0] total_bits,
    output logic [11:0] lit_cnt,
    output logic [11:0] match_cnt
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [63:0] acc;
    logic [6:0]  fill;
    logic        cw_fire;
    logic        is_match;
    logic [6:0]  len_in;
    logic [63:0] cw_left;
    logic [63:0] app;
    logic [63:0] merged;
    logic        out_free;
    logic        extract;
    logic        tail;
    logic [20:0] sum_bits;

    assign cw_ready = (state == RUN) && (fill <= 7'd53);
    assign cw_fire  = cw_valid && cw_ready;
    assign is_match = codeword[10];
    assign len_in   = cw_fire ? (is_match ? 7'd11 : 7'd9) : 7'd0;
    assign cw_left  = is_match ? {codeword, 53'd0}
                               : {codeword[10:2], 55'd0};
    // Bits below fill are always zero, so OR-ing in the aligned codeword appends it.
    assign app      = cw_fire ? (cw_left >> fill) : 64'd0;
    assign merged   = acc | app;
    assign out_free = !word_valid || word_ready;
    assign extract  = out_free && (fill >= 7'd32);
    assign tail     = (state == FLUSH) && out_free
                      && (fill != 7'd0) && (fill < 7'd32);
    assign sum_bits = {1'b0, total_bits} + 21'(len_in);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (finish) state_nx = FLUSH;
            end
            FLUSH: begin
                if (fill == 7'd0 && !word_valid) state_nx = DONE;
            end
            DONE: begin
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            acc        <= 64'd0;
            fill       <= 7'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            total_bits <= 20'd0;
        end else begin
            state <= state_nx;
            if (state == DONE) begin
                acc        <= 64'd0;
                fill       <= 7'd0;
                total_bits <= 20'd0;
            end else begin
                if (extract) begin
                    acc  <= merged << 32;
                    fill <= 7'(fill + len_in - 7'd32);
                end else if (tail) begin
                    acc  <= 64'd0;
                    fill <= 7'd0;
                end else begin
                    acc  <= merged;
                    fill <= 7'(fill + len_in);
                end
                if (cw_fire) begin
                    total_bits <= sum_bits[20] ? 20'hFFFFF : sum_bits[19:0];
                end
            end
            if (extract || tail) begin
                word       <= acc[63:32];
                word_valid <= 1'b1;
                word_last  <= tail;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
                word_last  <= 1'b0;
            end
        end
    end

`ifdef LZSS_PACK_STAT_EN
    always_ff @(posedge clk) begin
        if (reset || state == DONE) begin
            lit_cnt   <= 12'd0;
            match_cnt <= 12'd0;
        end else if (cw_fire) begin
            if (is_match) begin
                if (match_cnt != 12'hFFF) match_cnt <= match_cnt + 12'd1;
            end else begin
                if (lit_cnt != 12'hFFF) lit_cnt <= lit_cnt + 12'd1;
            end
        end
    end
`else
    assign lit_cnt   = 12'd0;
    assign match_cnt = 12'd0;
`endif

endmodule

// File: tb/tb_lzss_packer.sv
// Bench for lzss_packer: table of streams, bit-queue model and word scoreboard.
// Build with LZSS_PACK_STAT_EN defined to check the statistics counters.
module tb_lzss_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] codeword;
    logic        cw_valid;
    logic        cw_ready;
    logic        finish;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        word_last;
    logic        done;
    logic [19:0] total_bits;
    logic [11:0] lit_cnt;
    logic [11:0] match_cnt;

    lzss_packer dut (
        .clk(clk), .reset(reset), .codeword(codeword),
        .cw_valid(cw_valid), .cw_ready(cw_ready), .finish(finish),
        .word(word), .word_valid(word_valid), .word_ready(word_ready),
        .word_last(word_last), .done(done), .total_bits(total_bits),
        .lit_cnt(lit_cnt), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nlit;
        int          nmatch;
        logic [10:0] lit_cw;
        logic [10:0] match_cw;
        int          stall;
        bit          bp;
        int          total;
        int          nwords;
        int          nchk;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t        vecs[6];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          stall_end = 0;
    bit          bp_rand = 1'b0;
    bit          saw_bp = 1'b0;
    bit          bq[$];
    logic [31:0] exp_w[$];
    logic        exp_l[$];
    logic [31:0] got_w[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_word = 32'd0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, want event", name);
    endtask

    task automatic model_push(logic [10:0] cw);
        int n;
        logic [31:0] w;
        n = cw[10] ? 11 : 9;
        for (int i = 0; i < n; i++) bq.push_back(cw[10-i]);
        while (bq.size() >= 32) begin
            w = 32'd0;
            for (int i = 0; i < 32; i++) w = {w[30:0], bq.pop_front()};
            exp_w.push_back(w);
            exp_l.push_back(1'b0);
        end
    endtask

    task automatic model_finish();
        logic [31:0] w;
        if (bq.size() > 0) begin
            w = 32'd0;
            for (int i = 0; i < 32; i++)
                w = {w[30:0], (bq.size() > 0) ? bq.pop_front() : 1'b0};
            exp_w.push_back(w);
            exp_l.push_back(1'b1);
        end
    endtask

    // Downstream ready: held low for a stall window, else always or random.
    initial begin
        word_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc < stall_end) word_ready = 1'b0;
            else if (bp_rand) word_ready = 1'($urandom % 2);
            else word_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] ew;
        logic        el;
        if (prev_hold) begin
            chk("hold_word", word, prev_word);
            chk("hold_valid", 32'(word_valid), 32'd1);
        end
        if (!reset && word_valid && word_ready) begin
            if (exp_w.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %h, want none", word);
            end else begin
                ew = exp_w.pop_front();
                el = exp_l.pop_front();
                chk("word", word, ew);
                chk("word_last", 32'(word_last), 32'(el));
            end
            got_w.push_back(word);
        end
        prev_hold = word_valid && !word_ready && !reset;
        prev_word = word;
    end

    task automatic send(logic [10:0] cw);
        int t;
        t = 0;
        codeword = cw;
        cw_valid = 1'b1;
        @(negedge clk);
        while (!cw_ready && t < 300) begin
            saw_bp = 1'b1;
            t++;
            @(negedge clk);
        end
        if (!cw_ready) fail_now("cw_ready_wait");
        else model_push(cw);
        @(posedge clk);
        #1;
        cw_valid = 1'b0;
    endtask

    task automatic run_vec(int idx);
        vec_t v;
        int   t;
        int   el;
        int   em;
        v = vecs[idx];
        got_w.delete();
        saw_bp = 1'b0;
        stall_end = cyc + v.stall;
        bp_rand = v.bp;
        for (int i = 0; i < v.nlit; i++) send(v.lit_cw);
        for (int i = 0; i < v.nmatch; i++) send(v.match_cw);
        finish = 1'b1;
        model_finish();
        @(posedge clk);
        #1;
        finish = 1'b0;
        t = 0;
        @(negedge clk);
        while (!done && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (!done) begin
            fail_now("done_wait");
        end else begin
`ifdef LZSS_PACK_STAT_EN
            el = v.nlit;
            em = v.nmatch;
`else
            el = 0;
            em = 0;
`endif
            chk("total_bits", 32'(total_bits), 32'(v.total));
            chk("lit_cnt", 32'(lit_cnt), 32'(el));
            chk("match_cnt", 32'(match_cnt), 32'(em));
            chk("exp_left", 32'(exp_w.size()), 32'd0);
            chk("nwords", 32'(got_w.size()), 32'(v.nwords));
            if (v.nchk >= 1 && got_w.size() >= 1) chk("w0", got_w[0], v.w0);
            if (v.nchk >= 2 && got_w.size() >= 2) chk("w1", got_w[1], v.w1);
            if (v.stall > 0) chk("backpressure", 32'(saw_bp), 32'd1);
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
            chk("ready_after", 32'(cw_ready), 32'd1);
            chk("total_clr", 32'(total_bits), 32'd0);
        end
        bp_rand = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hits;
        vecs[0] = '{4, 0, 11'h104, 11'h7FF, 0, 1'b0, 36, 2, 2,
                    32'h20904824, 32'h10000000};
        vecs[1] = '{0, 3, 11'h104, 11'h7FF, 0, 1'b0, 33, 2, 2,
                    32'hFFFFFFFF, 32'h80000000};
        vecs[2] = '{32, 0, 11'h104, 11'h7FF, 0, 1'b0, 288, 9, 1,
                    32'h20904824, 32'h0};
        vecs[3] = '{0, 12, 11'h104, 11'h5A3, 20, 1'b0, 132, 5, 0,
                    32'h0, 32'h0};
        vecs[4] = '{5, 2, 11'h0FC, 11'h600, 0, 1'b0, 67, 3, 0,
                    32'h0, 32'h0};
        vecs[5] = '{7, 7, 11'h107, 11'h4C5, 0, 1'b1, 140, 5, 0,
                    32'h0, 32'h0};

        reset = 1'b1;
        codeword = 11'd0;
        cw_valid = 1'b0;
        finish = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word", word, 32'd0);
        chk("rst_word_last", 32'(word_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_total", 32'(total_bits), 32'd0);
        chk("rst_lit", 32'(lit_cnt), 32'd0);
        chk("rst_match", 32'(match_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cw_ready", 32'(cw_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset one cycle into FLUSH with 20 bits buffered.
        send(11'h104);
        send(11'h7FF);
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        reset = 1'b1;
        bq.delete();
        exp_w.delete();
        exp_l.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("flush_rst_ready", 32'(cw_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (word_valid || done) hits++;
            @(negedge clk);
        end
        chk("flush_rst_quiet", 32'(hits), 32'd0);
        @(posedge clk);
        #1;

        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lzss_packer.md
LZSS_PACKER -- requirements
Module: lzss_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port codeword, input, 11 bits: encoder output. Bit 10 = 0 means a literal, and bits [10:2] (9 bits) are valid. Bit 10 = 1 means a match, and all 11 bits are valid.
REQ-004 SHALL have port cw_valid, input, 1 bit: codeword is valid this cycle.
REQ-005 SHALL have port cw_ready, output, 1 bit: the packer can accept a codeword this cycle.
REQ-006 SHALL have port finish, input, 1 bit: one-cycle pulse marking the end of the stream.
REQ-007 SHALL have port word, output, 32 bits: packed output word, MSB-first.
REQ-008 SHALL have port word_valid, output, 1 bit: word holds valid data.
REQ-009 SHALL have port word_ready, input, 1 bit: downstream accepts word.
REQ-010 SHALL have port word_last, output, 1 bit: the current word is the zero-padded tail word.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the stream is completely drained.
REQ-012 SHALL have port total_bits, output, 20 bits: count of payload bits packed; valid while done is high.
REQ-013 SHALL have ports lit_cnt and match_cnt, output, 12 bits each: codeword statistics (see REQ-031).

Function
REQ-014 SHALL complete a codeword transfer when cw_valid && cw_ready at a clock edge; no other condition transfers a codeword.
REQ-015 SHALL append each transferred codeword's valid bits to a 64-bit accumulator immediately after the existing bits, MSB first: 9 bits for a literal, 11 bits for a match.
REQ-016 SHALL drive cw_ready high only in state RUN with fill <= 53, where fill is the accumulator bit count (0..64).
REQ-017 SHALL extract the upper 32 accumulator bits into the output register when fill >= 32 and the output register is empty or being consumed (word_valid && word_ready) in the same cycle.
REQ-018 SHALL update fill as next_fill = fill + len_in - (extract ? 32 : 0); an append and an extract SHALL be allowed in the same cycle.
REQ-019 SHALL hold word, word_valid and word_last stable while word_valid && !word_ready, and SHALL lose or duplicate no bits.
REQ-020 SHALL implement three states, RUN, FLUSH and DONE, with these transitions:
- RUN -> FLUSH on finish, with any codeword transferred in the same cycle included.
- FLUSH -> DONE once fill = 0 and the output register is empty.
- DONE -> RUN after exactly one cycle.
REQ-021 SHALL behave as follows in FLUSH:
- cw_ready = 0, and codewords SHALL be ignored.
- Full words SHALL drain first.
- If 0 < fill < 32, one word SHALL be emitted holding the remaining bits left-justified and zero-padded, with word_last = 1.
- If fill = 0 at flush, no tail word SHALL be emitted and word_last SHALL never assert.
REQ-022 SHALL assert done for exactly one cycle in DONE, with total_bits equal to the sum of all appended bit lengths since the last reset or DONE.
REQ-023 SHALL clear the accumulator, fill and total_bits on leaving DONE, so the next stream starts empty.
REQ-024 SHALL ignore finish when it arrives outside RUN.
REQ-025 SHALL saturate total_bits at 2^20-1.

Reset
REQ-026 SHALL, when reset is high at a clock edge, set:
- state = RUN, fill = 0, accumulator = 0
- word = 0, word_valid = 0, word_last = 0
- done = 0, total_bits = 0, lit_cnt = 0, match_cnt = 0
REQ-027 SHALL drive cw_ready = 1 in the first cycle after reset is released.
REQ-028 SHALL, on a reset in any state (including mid-FLUSH), discard all buffered bits and the pending output word with no further word_valid or done.
REQ-029 SHALL give reset priority over every simultaneous event.

Configuration
REQ-030 SHALL use the macro LZSS_PACK_STAT_EN.
REQ-031 SHALL, when LZSS_PACK_STAT_EN is defined:
- lit_cnt and match_cnt increment on each transferred literal or match codeword respectively.
- Both saturate at 4095.
- Both hold their values while done is high and clear together with total_bits.
REQ-032 SHALL, when LZSS_PACK_STAT_EN is not defined, tie lit_cnt and match_cnt to 0 and instantiate no counter logic.

Verification
REQ-033 SHALL cover: 4 literals codeword=0x104, then finish, word_ready=1 -> word 0x20904824, then word 0x10000000 with word_last=1, done with total_bits=36.
REQ-034 SHALL cover: 3 matches codeword=0x7FF, then finish -> word 0xFFFFFFFF, then word 0x80000000 with word_last=1, total_bits=33.
REQ-035 SHALL cover: 32 literals, then finish -> exactly 9 words, word_last never asserted, done with total_bits=288.
REQ-036 SHALL cover: word_ready=0 for 20 cycles while matches are offered every cycle -> cw_ready drops once fill > 53; after release the word sequence is bit-exact with no loss.
REQ-037 SHALL cover: reset asserted 1 cycle into FLUSH with fill=20 -> no word_valid, no done, cw_ready=1 next cycle.
REQ-038 SHALL cover: with LZSS_PACK_STAT_EN defined, 5 literals and 2 matches, then finish -> lit_cnt=5, match_cnt=2, total_bits=67 at done.
